// File: rtl/scroll_text_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : scroll_text_display_driver
// Purpose  : Multiplexes a 40-bit, 8-character text window onto an 8-digit
//            active-low seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module scroll_text_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [39:0] instruction,
    input  logic        display_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int          c_PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(REFRESH_DIV - 1);

    logic [c_PW-1:0] prescaler_q, prescaler_d;
    logic [2:0]      idx_q, idx_d;
    logic [39:0]     snap_q, snap_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            fd_q, fd_d;
    logic            en_q;

    logic            w_tick;
    logic [5:0]      w_shamt;
    logic [39:0]     w_shifted;
    logic [4:0]      w_char;
    logic [7:0]      w_an_dec;

    // Active-high gfedcba glyph for a 5-bit character code
    function automatic logic [6:0] glyph(input logic [4:0] code);
        case (code)
            5'd1:  glyph = 7'h77;  5'd2:  glyph = 7'h7C;  5'd3:  glyph = 7'h39;
            5'd4:  glyph = 7'h5E;  5'd5:  glyph = 7'h79;  5'd6:  glyph = 7'h71;
            5'd7:  glyph = 7'h3D;  5'd8:  glyph = 7'h76;  5'd9:  glyph = 7'h30;
            5'd10: glyph = 7'h1E;  5'd11: glyph = 7'h75;  5'd12: glyph = 7'h38;
            5'd13: glyph = 7'h37;  5'd14: glyph = 7'h54;  5'd15: glyph = 7'h3F;
            5'd16: glyph = 7'h73;  5'd17: glyph = 7'h67;  5'd18: glyph = 7'h50;
            5'd19: glyph = 7'h6D;  5'd20: glyph = 7'h78;  5'd21: glyph = 7'h3E;
            5'd22: glyph = 7'h1C;  5'd23: glyph = 7'h2A;  5'd24: glyph = 7'h76;
            5'd25: glyph = 7'h6E;  5'd26: glyph = 7'h5B;  5'd27: glyph = 7'h40;
            default: glyph = 7'h00;
        endcase
    endfunction

    always_comb begin
        w_tick      = (prescaler_q == c_LAST);
        prescaler_d = w_tick ? '0 : prescaler_q + 1'b1;
        idx_d       = idx_q;
        snap_d      = snap_q;
        fd_d        = 1'b0;
        if (w_tick) begin
            if (idx_q == 3'd7) begin
                idx_d  = 3'd0;
                snap_d = instruction;
                fd_d   = 1'b1;
            end else begin
                idx_d  = idx_q + 3'd1;
            end
        end

        // Char idx sits (7-idx)*5 bits above the LSB of the window
        w_shamt   = {3'b000, ~idx_d} * 6'd5;
        w_shifted = snap_d >> w_shamt;
        w_char    = w_shifted[4:0];
        seg_d     = ~glyph(w_char);
        w_an_dec  = ~(8'h80 >> idx_d);

        // en_q catches the 0->1 edge so the anode is restored without waiting for a tick
        if (!display_en)
            an_d = 8'hFF;
        else if (w_tick || !en_q)
            an_d = w_an_dec;
        else
            an_d = an_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler_q <= '0;
            idx_q       <= 3'd7;
            snap_q      <= 40'd0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            fd_q        <= 1'b0;
            en_q        <= 1'b1;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            fd_q        <= fd_d;
            en_q        <= display_en;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_scroll_text_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_scroll_text_display_driver
// Purpose  : Scoreboard bench for scroll_text_display_driver (DIV=4 and DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scroll_text_display_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [39:0] instruction;
    logic        display_en = 1'b1;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    logic        rst1 = 1'b1;
    logic [39:0] instr1;
    logic [7:0]  an1;
    logic [6:0]  seg1;
    logic        fd1;

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;

    localparam logic [39:0] c_CONVERT = {5'd3, 5'd15, 5'd14, 5'd22, 5'd5, 5'd18, 5'd20, 5'd0};
    localparam logic [39:0] c_DASHES  = {8{5'd27}};
    localparam logic [39:0] c_CODES   = {5'd0, 5'd28, 5'd29, 5'd30, 5'd31, 5'd27, 5'd1, 5'd26};

    logic [6:0] conv_seg [8] = '{7'h46, 7'h40, 7'h2B, 7'h63, 7'h06, 7'h2F, 7'h07, 7'h7F};
    logic [6:0] code_seg [8] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h08, 7'h24};

    scroll_text_display_driver #(.REFRESH_DIV(4)) u_dut (
        .clock(clock), .reset(reset), .instruction(instruction),
        .display_en(display_en), .an(an), .seg(seg), .frame_done(frame_done)
    );

    scroll_text_display_driver #(.REFRESH_DIV(1)) u_dut1 (
        .clock(clock), .reset(rst1), .instruction(instr1),
        .display_en(1'b1), .an(an1), .seg(seg1), .frame_done(fd1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         dut;
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic push(input int c, input bit d, input logic [7:0] a,
                        input logic [6:0] s, input logic f, input string n);
        exp_t x;
        x.cyc = c; x.dut = d; x.an = a; x.seg = s; x.fd = f; x.name = n;
        sb.push_back(x);
    endtask

    task automatic chk(input string n, input string fld, input int c,
                       input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s.%s cyc=%0d got=%h expected=%h", n, fld, c, got, want);
        end
    endtask

    function automatic logic [7:0] an_of(input int k);
        logic [7:0] one;
        one = 8'h80;
        return ~(one >> k);
    endfunction

    // Monitor: compares every entry due at the current cycle
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_checks++;
                n_err++;
                $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else if (e.dut) begin
                chk(e.name, "an",  cyc, an1, e.an);
                chk(e.name, "seg", cyc, {1'b0, seg1}, {1'b0, e.seg});
                chk(e.name, "fd",  cyc, {7'd0, fd1}, {7'd0, e.fd});
            end else begin
                chk(e.name, "an",  cyc, an, e.an);
                chk(e.name, "seg", cyc, {1'b0, seg}, {1'b0, e.seg});
                chk(e.name, "fd",  cyc, {7'd0, frame_done}, {7'd0, e.fd});
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    initial begin
        instruction = c_CONVERT;
        instr1      = c_CONVERT;

        // Expected timeline (cycle = number of posedges seen)
        for (int c = 1; c <= 6; c++) push(c, 0, 8'hFF, 7'h7F, 1'b0, "reset");
        push(7, 0, 8'h7F, 7'h46, 1'b1, "first_tick");
        push(8, 0, 8'h7F, 7'h46, 1'b0, "fd_pulse");
        for (int k = 1; k < 8; k++) push(7 + 4*k, 0, an_of(k), conv_seg[k], 1'b0, "frame1");
        for (int k = 0; k < 8; k++) begin
            push(39 + 4*k, 0, an_of(k), 7'h3F, k == 0, "frame2_dash");
            if (k == 2) begin
                push(48, 0, 8'hFF, 7'h3F, 1'b0, "en_drop");
                push(49, 0, 8'hFF, 7'h3F, 1'b0, "en_low");
                push(50, 0, an_of(2), 7'h3F, 1'b0, "en_restore");
            end
        end
        for (int k = 0; k < 6; k++) push(71 + 4*k, 0, an_of(k), code_seg[k], k == 0, "frame3_codes");
        push(92,  0, an_of(5), 7'h3F, 1'b0, "pre_reset");
        push(93,  0, 8'hFF, 7'h7F, 1'b0, "mid_reset");
        push(96,  0, 8'hFF, 7'h7F, 1'b0, "post_reset_idle");
        push(97,  0, 8'h7F, 7'h7F, 1'b1, "post_reset_frame");
        push(101, 0, 8'hBF, 7'h7F, 1'b0, "post_reset_idx1");
        push(102, 1, 8'hFF, 7'h7F, 1'b0, "div1_reset");
        for (int k = 0; k < 16; k++)
            push(103 + k, 1, an_of(k % 8), conv_seg[k % 8], (k % 8) == 0, "div1_run");

        wait_cyc(3);  reset = 1'b0;
        wait_cyc(20); instruction = c_DASHES;
        wait_cyc(47); display_en = 1'b0;
        wait_cyc(49); display_en = 1'b1;
        wait_cyc(60); instruction = c_CODES;
        wait_cyc(92); reset = 1'b1;
        wait_cyc(93); reset = 1'b0;
        wait_cyc(102); rst1 = 1'b0;
        wait_cyc(122);

        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scroll_text_display_driver.md
Name: scroll_text_display_driver

Overview:
- Reader end of the 40-bit scrolling-text window bus that `convert_currency` drives as its `instruction` output.
- The window holds 8 characters of 5 bits each. Char 0 (leftmost) is bits [39:35]; char 7 is bits [4:0].
- The block snapshots the window once per refresh frame, so a frame never mixes two window states.
- It time-multiplexes the 8 characters onto an 8-digit common-anode seven-segment display. Anodes and segments are active-low.

Parameters:
- REFRESH_DIV, default 100000: system clocks per digit slot. Legal range 1..2^20.
- At 100 MHz the default gives 1 kHz per digit and 125 Hz per frame.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- instruction, input, 40: character window. The source may change it at any time.
- display_en, input, 1: 1 = drive the display; 0 = all anodes off.
- an, output, 8: digit anodes, active-low. an[7] is the leftmost digit and shows char 0.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- frame_done, output, 1: one-cycle pulse on the cycle a new snapshot is taken.

Behaviour:
- Reset (synchronous, active-high), state on the cycle after reset is sampled high:
  - prescaler = 0
  - idx = 7
  - snapshot = 0 (all blank)
  - an = 8'hFF
  - seg = 7'h7F
  - frame_done = 0
- Reset asserted mid-frame: the same reset values apply on the next edge. The partial frame is discarded.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1).
  - With REFRESH_DIV=1, tick is high every cycle.
- Digit index update, on tick only:
  - If idx == 7: idx_n = 0, snapshot_n = instruction, frame_done = 1 for that cycle.
  - Otherwise: idx_n = idx+1, snapshot_n = snapshot.
  - Between ticks, idx and snapshot hold and frame_done = 0.
- First frame after reset: the first tick wraps idx from 7 to 0 and takes the snapshot.
- Outputs are registered and update on the tick edge, computed from idx_n and snapshot_n:
  - char = snapshot_n[39-5*idx_n -: 5]
  - an = display_en ? ~(8'b1000_0000 >> idx_n) : 8'hFF
  - seg = ~glyph(char)
  - Net effect: an and seg change together, with no one-digit skew.
- display_en:
  - Sampled on every cycle, not only on tick.
  - A 1→0 change forces an = 8'hFF on the next edge.
  - A 0→1 change restores an from the current idx on the next edge.
  - seg, idx and snapshot keep running regardless of display_en.
- Changes on instruction mid-frame are invisible until the next wrap (idx 7→0).
- Glyph table, active-high gfedcba:
  - 0 = blank 00
  - A 77, B 7C, C 39, D 5E, E 79, F 71, G 3D, H 76, I 30, J 1E, K 75, L 38, M 37
  - N 54, O 3F, P 73, Q 67, R 50, S 6D, T 78, U 3E, V 1C, W 2A, X 76, Y 6E, Z 5B
  - Code-to-letter mapping: code 1..26 = A..Z.
  - 27 = dash 40
  - 28..31 = blank 00
- Purely synchronous design. No combinational path from instruction or display_en to the outputs.

Test Plan:
1. Reset and first frame. REFRESH_DIV=4, hold reset 3 cycles.
   - During reset and afterwards until the first tick: an=FF, seg=7F.
   - The first tick is 4 clocks after reset release. On that edge: an=7F, frame_done=1, and seg shows char 0.
2. Full frame with instruction = {C,O,N,V,E,R,T,blank} = {03,0F,0E,16,05,12,14,00}.
   - Successive ticks give (an, seg): (7F,46), (BF,40), (DF,2B), (EF,63), (F7,06), (FB,2F), (FD,07), (FE,7F).
   - frame_done pulses only at the first of these.
3. Tear-free update. Change instruction to all 5'b11011 (dash) while idx=3.
   - Digits 4..7 still show the old characters.
   - At the next wrap: frame_done=1 and every digit shows seg=3F.
4. display_en. Drop display_en for 2 cycles mid-slot.
   - an=FF exactly one edge after the drop.
   - an restores to the same digit one edge after display_en returns.
   - The tick spacing of idx is unchanged.
5. Boundary settings:
   - REFRESH_DIV=1: idx advances every clock; frame_done high 1 of every 8 cycles.
   - Codes 28..31 give seg=7F. Code 0 gives seg=7F.
6. Mid-frame reset. Assert reset at idx=5 for 1 cycle.
   - Next edge: an=FF, seg=7F, idx=7.
   - A new frame starts REFRESH_DIV cycles after release.
